// File: rtl/clock_manager.sv
// clock_manager: PLL lock synchroniser/debouncer, reset sequencer and
// CHANNELS phase-accumulator (NCO) tick/clock generators.
// Optional feature macro CLOCK_MANAGER_PHASE_EN adds phase_in, a per-channel
// accumulator preload applied on the edge that enters RUN.
module clock_manager #(
    parameter int unsigned CHANNELS           = 2,
    parameter int unsigned ACC_WIDTH          = 16,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned LOSS_CNT_WIDTH     = 8
) (
    input  logic                          clock_in,
    input  logic                          reset,
    input  logic                          pll_locked,
`ifdef CLOCK_MANAGER_PHASE_EN
    input  logic [CHANNELS*ACC_WIDTH-1:0] phase_in,
`endif
    input  logic [CHANNELS*ACC_WIDTH-1:0] inc,
    output logic                          locked,
    output logic                          reset_out,
    output logic [CHANNELS-1:0]           tick,
    output logic [CHANNELS-1:0]           clk_out,
    output logic [LOSS_CNT_WIDTH-1:0]     loss_count
);

    localparam int unsigned CntWidth =
        (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StWaitLock,
        StStabilize,
        StRun,
        StLost
    } state_e;

    state_e                      state_q, state_d;
    logic [CntWidth-1:0]         cnt_q, cnt_d;
    logic                        sync1_q, sync2_q;
    logic [LOSS_CNT_WIDTH-1:0]   loss_q, loss_d;

    logic [CHANNELS-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CHANNELS-1:0]                tick_q, tick_d;
    logic [CHANNELS-1:0]                clk_q, clk_d;

    logic run_now, run_next;

    // Synchroniser, lock state machine and lock-loss counter registers
    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= StWaitLock;
            cnt_q   <= '0;
            loss_q  <= '0;
        end else begin
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            loss_q  <= loss_d;
        end
    end

    // Lock debounce sequencing and saturating loss count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        unique case (state_q)
            StWaitLock: begin
                cnt_d = '0;
                if (sync2_q) state_d = StStabilize;
            end
            StStabilize: begin
                if (!sync2_q) begin
                    // Any dip restarts the stability window
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!sync2_q) state_d = StLost;
            end
            StLost: begin
                state_d = StWaitLock;
                if (loss_q != {LOSS_CNT_WIDTH{1'b1}}) loss_d = loss_q + 1'b1;
            end
            default: state_d = StWaitLock;
        endcase
    end

    assign run_now  = (state_q == StRun);
    // Gating on the next state keeps tick/clk_out at 0 from the edge that leaves RUN
    assign run_next = (state_d == StRun);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_nco
        logic [ACC_WIDTH:0]   sum;
        logic [ACC_WIDTH-1:0] start;

        assign sum = {1'b0, acc_q[k]} + {1'b0, inc[k*ACC_WIDTH +: ACC_WIDTH]};
`ifdef CLOCK_MANAGER_PHASE_EN
        assign start = phase_in[k*ACC_WIDTH +: ACC_WIDTH];
`else
        assign start = '0;
`endif
        assign acc_d[k]  = !run_next ? '0 : (!run_now ? start : sum[ACC_WIDTH-1:0]);
        assign tick_d[k] = run_next & run_now & sum[ACC_WIDTH];
        assign clk_d[k]  = run_next & run_now & sum[ACC_WIDTH-1];
    end

    // NCO accumulator and output registers
    always_ff @(posedge clock_in) begin
        if (reset) begin
            acc_q  <= '0;
            tick_q <= '0;
            clk_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
            clk_q  <= clk_d;
        end
    end

    assign locked     = (state_q == StRun);
    assign reset_out  = (state_q != StRun);
    assign tick       = tick_q;
    assign clk_out    = clk_q;
    assign loss_count = loss_q;

endmodule

// File: tb/tb_clock_manager.sv
// Testbench for clock_manager: lock latency, glitch rejection, NCO rates,
// lock loss with counter saturation, reset mid-RUN and (with
// CLOCK_MANAGER_PHASE_EN) programmable phase offset.
module tb_clock_manager;

    localparam int unsigned CH  = 2;
    localparam int unsigned AW  = 8;
    localparam int unsigned LSC = 4;
    localparam int unsigned LW  = 8;
    localparam int unsigned MOD = 1 << AW;

    logic              clock_in = 1'b0;
    logic              reset = 1'b1;
    logic              pll_locked = 1'b0;
    logic [CH*AW-1:0]  inc = '0;
`ifdef CLOCK_MANAGER_PHASE_EN
    logic [CH*AW-1:0]  phase_in = '0;
`endif
    logic              locked;
    logic              reset_out;
    logic [CH-1:0]     tick;
    logic [CH-1:0]     clk_out;
    logic [LW-1:0]     loss_count;

    int vectors = 0;
    int miscompares = 0;
    int exp_loss = 0;
    int unsigned acc_m [CH];

    always #5 clock_in = ~clock_in;

    clock_manager #(
        .CHANNELS(CH),
        .ACC_WIDTH(AW),
        .LOCK_STABLE_CYCLES(LSC),
        .LOSS_CNT_WIDTH(LW)
    ) dut (
        .clock_in(clock_in),
        .reset(reset),
        .pll_locked(pll_locked),
`ifdef CLOCK_MANAGER_PHASE_EN
        .phase_in(phase_in),
`endif
        .inc(inc),
        .locked(locked),
        .reset_out(reset_out),
        .tick(tick),
        .clk_out(clk_out),
        .loss_count(loss_count)
    );

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        pll_locked = 1'b0;
        inc = '0;
        repeat (n) step();
        reset = 1'b0;
        exp_loss = 0;
    endtask

    // Hold lock high for exactly the documented lock latency
    task automatic bring_up();
        pll_locked = 1'b1;
        repeat (LSC + 3) step();
    endtask

    task automatic test_reset();
        do_reset(2);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++; $display("FAIL reset_locked: got %b want 0", locked);
        end
        vectors++;
        if (reset_out !== 1'b1) begin
            miscompares++; $display("FAIL reset_reset_out: got %b want 1", reset_out);
        end
        vectors++;
        if (tick !== '0) begin
            miscompares++; $display("FAIL reset_tick: got %b want 00", tick);
        end
        vectors++;
        if (clk_out !== '0) begin
            miscompares++; $display("FAIL reset_clk_out: got %b want 00", clk_out);
        end
        vectors++;
        if (loss_count !== '0) begin
            miscompares++; $display("FAIL reset_loss_count: got %0d want 0", loss_count);
        end
    endtask

    task automatic test_lock_latency();
        logic exp;
        do_reset(2);
        pll_locked = 1'b1;
        for (int i = 1; i <= int'(LSC) + 3; i++) begin
            step();
            exp = (i == int'(LSC) + 3);
            vectors++;
            if (locked !== exp) begin
                miscompares++;
                $display("FAIL latency_locked edge %0d: got %b want %b", i, locked, exp);
            end
            vectors++;
            if (reset_out !== !exp) begin
                miscompares++;
                $display("FAIL latency_reset_out edge %0d: got %b want %b", i, reset_out, !exp);
            end
        end
        vectors++;
        if (loss_count !== '0) begin
            miscompares++; $display("FAIL latency_loss_count: got %0d want 0", loss_count);
        end
    endtask

    task automatic test_glitch();
        int  h;
        logic exp;
        for (int t = 0; t < 4; t++) begin
            do_reset(2);
            h = (t == 0) ? 3 : int'($urandom_range(1, LSC));
            pll_locked = 1'b1;
            for (int j = 0; j <= h; j++) begin
                if (j == h) pll_locked = 1'b0;
                step();
                vectors++;
                if (locked !== 1'b0) begin
                    miscompares++;
                    $display("FAIL glitch_pre h=%0d step %0d: got %b want 0", h, j, locked);
                end
            end
            pll_locked = 1'b1;
            for (int i = 1; i <= int'(LSC) + 3; i++) begin
                step();
                exp = (i == int'(LSC) + 3);
                vectors++;
                if (locked !== exp) begin
                    miscompares++;
                    $display("FAIL glitch_relock h=%0d edge %0d: got %b want %b",
                             h, i, locked, exp);
                end
            end
        end
    endtask

    task automatic test_nco();
        int unsigned s;
        int unsigned iv;
        int first0;
        logic [CH-1:0] et, ec;
        do_reset(2);
`ifdef CLOCK_MANAGER_PHASE_EN
        phase_in = '0;
`endif
        for (int k = 0; k < int'(CH); k++) acc_m[k] = 0;
        inc = {8'd128, 8'd64};
        bring_up();
        first0 = 0;
        for (int c = 1; c <= 64; c++) begin
            if (c == 17) inc = {8'd128, 8'd0};
            if (c >= 25) inc = CH*AW'($urandom);
            step();
            for (int k = 0; k < int'(CH); k++) begin
                iv = int'(inc[k*AW +: AW]);
                s = acc_m[k] + iv;
                et[k] = (s >= MOD);
                acc_m[k] = s % MOD;
                ec[k] = (acc_m[k] >= MOD / 2);
            end
            if (tick[0] === 1'b1 && first0 == 0) first0 = c;
            vectors++;
            if (tick !== et) begin
                miscompares++;
                $display("FAIL nco_tick cycle %0d inc=%h: got %b want %b", c, inc, tick, et);
            end
            vectors++;
            if (clk_out !== ec) begin
                miscompares++;
                $display("FAIL nco_clk_out cycle %0d inc=%h: got %b want %b",
                         c, inc, clk_out, ec);
            end
        end
        vectors++;
        if (first0 != 4) begin
            miscompares++; $display("FAIL nco_first_tick0: got cycle %0d want 4", first0);
        end
    endtask

    task automatic test_lock_loss();
        int  d;
        logic exp;
        do_reset(2);
        inc = CH*AW'($urandom);
        bring_up();
        for (int it = 0; it < 300; it++) begin
            d = (it == 0) ? 3 : int'($urandom_range(3, 5));
            pll_locked = 1'b0;
            for (int j = 1; j <= d; j++) begin
                step();
                exp = (j < 3);
                if (j <= 3) begin
                    vectors++;
                    if (locked !== exp || reset_out !== !exp) begin
                        miscompares++;
                        $display("FAIL loss_flags iter %0d edge %0d: locked=%b reset_out=%b want %b/%b",
                                 it, j, locked, reset_out, exp, !exp);
                    end
                end
                if (j == 3) begin
                    vectors++;
                    if (tick !== '0 || clk_out !== '0) begin
                        miscompares++;
                        $display("FAIL loss_outputs iter %0d: tick=%b clk_out=%b want 00/00",
                                 it, tick, clk_out);
                    end
                end
            end
            exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
            pll_locked = 1'b1;
            for (int i = 1; i <= int'(LSC) + 3; i++) begin
                step();
                if (i >= int'(LSC) + 2) begin
                    exp = (i == int'(LSC) + 3);
                    vectors++;
                    if (locked !== exp) begin
                        miscompares++;
                        $display("FAIL loss_relock iter %0d edge %0d: got %b want %b",
                                 it, i, locked, exp);
                    end
                end
            end
            vectors++;
            if (loss_count !== LW'(exp_loss)) begin
                miscompares++;
                $display("FAIL loss_count iter %0d: got %0d want %0d", it, loss_count, exp_loss);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic exp;
        do_reset(2);
        inc = {8'd128, 8'd64};
        bring_up();
        // One loss first so that reset has a nonzero count to clear
        pll_locked = 1'b0;
        repeat (3) step();
        bring_up();
        repeat (6) step();
        vectors++;
        if (loss_count !== LW'(1)) begin
            miscompares++; $display("FAIL midrun_pre_count: got %0d want 1", loss_count);
        end
        reset = 1'b1;
        step();
        vectors++;
        if (locked !== 1'b0 || reset_out !== 1'b1) begin
            miscompares++;
            $display("FAIL midrun_flags: locked=%b reset_out=%b want 0/1", locked, reset_out);
        end
        vectors++;
        if (tick !== '0 || clk_out !== '0 || loss_count !== '0) begin
            miscompares++;
            $display("FAIL midrun_outputs: tick=%b clk_out=%b loss=%0d want 00/00/0",
                     tick, clk_out, loss_count);
        end
        reset = 1'b0;
        for (int i = 1; i <= int'(LSC) + 3; i++) begin
            step();
            exp = (i == int'(LSC) + 3);
            vectors++;
            if (locked !== exp) begin
                miscompares++;
                $display("FAIL midrun_relock edge %0d: got %b want %b", i, locked, exp);
            end
        end
    endtask

`ifdef CLOCK_MANAGER_PHASE_EN
    task automatic test_phase();
        int unsigned s;
        logic [CH-1:0] et, ec;
        do_reset(2);
        phase_in = {8'd128, 8'd0};
        acc_m[0] = 0;
        acc_m[1] = 128;
        inc = {8'd64, 8'd64};
        bring_up();
        phase_in = {8'd37, 8'd91};
        for (int c = 1; c <= 12; c++) begin
            step();
            for (int k = 0; k < int'(CH); k++) begin
                s = acc_m[k] + 64;
                et[k] = (s >= MOD);
                acc_m[k] = s % MOD;
                ec[k] = (acc_m[k] >= MOD / 2);
            end
            vectors++;
            if (tick !== et || clk_out !== ec) begin
                miscompares++;
                $display("FAIL phase cycle %0d: tick=%b clk_out=%b want %b/%b",
                         c, tick, clk_out, et, ec);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lock_latency();
        test_glitch();
        test_nco();
        test_lock_loss();
        test_reset_mid_run();
`ifdef CLOCK_MANAGER_PHASE_EN
        test_phase();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
